ex_mem_flag_reg: RTL
====================

// Module: ex_mem_flag_reg
// PURPOSE
//  EX->MEM boundary of the 5-stage pipeline. Registers the ALU result and its control into MEM.
//  Owns the architectural flag register {Z,V,N} and updates it per opcode from the ALU Flags bus.
//  Resolves branch conditions against the committed flags for the branch unit.
//  Raises a pending flag for the hazard unit when an in-flight EX op will change flags.
// PARAMETERS
//  DW    16  datapath width (ALU result, store data)
//  RW     4  destination register index width
// PORTS
//  clk             in   1   pipeline clock, all state on rising edge
//  rst             in   1   synchronous, active-high reset
//  stall           in   1   hold all EX/MEM and flag state this cycle
//  flush           in   1   squash the EX instruction (bubble into MEM)
//  ex_valid        in   1   EX holds a real instruction
//  ex_alu_op       in   3   ALU opcode: 0 ADD 1 SUB 2 XOR 3 RED 4 SLL 5 SRA 6 ROR 7 PADDSB
//  ex_is_alu       in   1   instruction is an ALU-format op (eligible to write flags)
//  ex_alu_out      in   DW  ALU result
//  ex_flags        in   3   ALU flags {Z,V,N} (bit2 Z, bit1 V, bit0 N)
//  ex_rd           in   RW  destination register
//  ex_reg_wen      in   1   writes register file
//  ex_mem_ren      in   1   load
//  ex_mem_wen      in   1   store
//  ex_store_data   in   DW  store data (forwarded rt)
//  ex_halt         in   1   HLT in EX
//  br_cond         in   3   condition code of branch in ID
//  mem_valid       out  1   MEM holds a real instruction
//  mem_alu_out     out  DW  registered ALU result / memory address
//  mem_rd          out  RW  registered destination
//  mem_reg_wen     out  1   registered, gated by mem_valid
//  mem_mem_ren     out  1   registered, gated by mem_valid
//  mem_mem_wen     out  1   registered, gated by mem_valid
//  mem_store_data  out  DW  registered store data
//  mem_halt        out  1   registered halt, gated by mem_valid
//  flag_z/v/n      out  1   committed flag register
//  flags_pending   out  1   EX op will update flags at next edge
//  br_taken        out  1   condition true on committed flags (combinational)
// BEHAVIOUR
//  Reset: all mem_* outputs 0, mem_valid 0, flag_z/v/n 0; dominates stall and flush.
//  Latency: one cycle EX->MEM; br_taken zero-latency from flag register (not from ex_flags).
//  Edge priority: rst > flush > stall > normal load.
//  flush (even with stall): MEM loads bubble (valid and all enables 0, data fields 0); flags unchanged.
//  stall (no flush): every register holds, flags hold.
//  Normal: MEM loads all ex_* fields; mem_valid <= ex_valid; enables forced 0 when !ex_valid.
//  Flag update (only when ex_valid & ex_is_alu & !stall & !flush):
//   ADD/SUB: Z,V,N <= ex_flags. XOR/SLL/SRA/ROR: Z only; V,N hold. RED/PADDSB: no change.
//  flags_pending = ex_valid & ex_is_alu & op in {0,1,2,4,5,6} & !flush; hazard unit stalls branch.
//  br_taken by br_cond: 000 NE !Z | 001 EQ Z | 010 GT !Z&!N | 011 LT N |
//   100 GE Z|(!Z&!N) | 101 LE N|Z | 110 OV V | 111 always 1.
//  No data arithmetic here; values pass unmodified at DW bits.
// TESTING
//  Reset: rst=1 one edge with ex_valid=1 -> all mem_* 0, flags 000, br_taken(001)=0, (111)=1.
//  ADD, ex_flags=3'b011, ex_alu_out=16'h8000 -> next edge Z=0 V=1 N=1, mem_alu_out=8000, br(110)=1.
//  After flags 011, XOR with ex_flags=3'b100 -> Z=1 V=1 N=1; then RED flags 000 -> flags stay 111.
//  stall=1 two cycles with new EX data -> mem_* and flags frozen; release -> loads on next edge.
//  flush=1 & stall=1, SUB ex_flags=100 -> mem_valid=0, enables 0, flags unchanged, flags_pending=0.
//  Sweep br_cond 0..7 over all 8 flag values -> br_taken matches table; ex_valid=0 -> enables 0.

Source files
------------

// File: rtl/ex_mem_flag_reg.sv
// ex_mem_flag_reg: EX->MEM pipeline register with the architectural {Z,V,N} flag
// register, branch condition resolution and a flags-pending hint for hazard logic.
module ex_mem_flag_reg #(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          ex_valid,
    input  logic [2:0]    ex_alu_op,
    input  logic          ex_is_alu,
    input  logic [DW-1:0] ex_alu_out,
    input  logic [2:0]    ex_flags,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_reg_wen,
    input  logic          ex_mem_ren,
    input  logic          ex_mem_wen,
    input  logic [DW-1:0] ex_store_data,
    input  logic          ex_halt,
    input  logic [2:0]    br_cond,
    output logic          mem_valid,
    output logic [DW-1:0] mem_alu_out,
    output logic [RW-1:0] mem_rd,
    output logic          mem_reg_wen,
    output logic          mem_mem_ren,
    output logic          mem_mem_wen,
    output logic [DW-1:0] mem_store_data,
    output logic          mem_halt,
    output logic          flag_z,
    output logic          flag_v,
    output logic          flag_n,
    output logic          flags_pending,
    output logic          br_taken
);
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_RED = 3'd3, OP_PADDSB = 3'd7;

    logic flag_upd, upd_all;

    assign flag_upd      = ex_valid & ex_is_alu & ~stall & ~flush;
    assign upd_all       = ex_alu_op == OP_ADD || ex_alu_op == OP_SUB;
    assign flags_pending = ex_valid & ex_is_alu & ~flush & ex_alu_op != OP_RED & ex_alu_op != OP_PADDSB;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            mem_valid      <= 1'b0;
            mem_alu_out    <= '0;
            mem_rd         <= '0;
            mem_reg_wen    <= 1'b0;
            mem_mem_ren    <= 1'b0;
            mem_mem_wen    <= 1'b0;
            mem_store_data <= '0;
            mem_halt       <= 1'b0;
        end else if (!stall) begin
            mem_valid      <= ex_valid;
            mem_alu_out    <= ex_alu_out;
            mem_rd         <= ex_rd;
            mem_reg_wen    <= ex_reg_wen & ex_valid;
            mem_mem_ren    <= ex_mem_ren & ex_valid;
            mem_mem_wen    <= ex_mem_wen & ex_valid;
            mem_store_data <= ex_store_data;
            mem_halt       <= ex_halt & ex_valid;
        end
    end

    // Logical/shift ops only define Z; V and N keep the last arithmetic result.
    always_ff @(posedge clk) begin
        if (rst) begin
            {flag_z, flag_v, flag_n} <= 3'b000;
        end else if (flag_upd && flags_pending) begin
            flag_z <= ex_flags[2];
            if (upd_all) {flag_v, flag_n} <= ex_flags[1:0];
        end
    end

    always_comb begin
        case (br_cond)
            3'd0:    br_taken = ~flag_z;
            3'd1:    br_taken = flag_z;
            3'd2:    br_taken = ~flag_z & ~flag_n;
            3'd3:    br_taken = flag_n;
            3'd4:    br_taken = flag_z | (~flag_z & ~flag_n);
            3'd5:    br_taken = flag_n | flag_z;
            3'd6:    br_taken = flag_v;
            default: br_taken = 1'b1;
        endcase
    end
endmodule
